// File: rtl/noise_lrelu_quant.sv
// Noise-injection + LeakyReLU + Q16.16->Q8.8 requantiser: three-stage AXI-Stream
// pipeline with a noise-map BRAM read port and frame position tracking.
module noise_lrelu_quant #(
  parameter int FRAC_SHIFT  = 8,
  parameter int LRELU_ALPHA = 13107
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [7:0]  Image_size,
  input  logic [8:0]  Channel_size,
  input  logic [15:0] noise_strength,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [13:0] noise_BRAM_addr,
  output logic        enb_noise_BRAM,
  input  logic [15:0] noise_BRAM_doutb,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        frame_err
);

  localparam logic signed [63:0] ALPHA_C = 64'(LRELU_ALPHA);
  localparam logic signed [63:0] ROUND_C = (64'sd1 <<< FRAC_SHIFT) >>> 1;

  function automatic logic [15:0] sat16(input logic signed [63:0] v);
    logic [15:0] r;
    if (v > 64'sd32767) begin
      r = 16'h7FFF;
    end else if (v < -64'sd32768) begin
      r = 16'h8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  logic               stall_s;
  logic               accept_s;
  logic [15:0]        size_sq_s;
  logic               last_pix_s;
  logic               last_ch_s;
  logic signed [31:0] noise_prod_s;
  logic [47:0]        noise_ext_s;
  logic signed [63:0] sum_ext_s;
  logic signed [63:0] slope_s;
  logic signed [63:0] act_s;
  logic signed [63:0] q_wide_s;
  logic               unused_s;

  logic        s1_valid_r;
  logic [47:0] s1_acc_r;
  logic        s1_last_r;
  logic        s2_valid_r;
  logic [47:0] s2_sum_r;
  logic        s2_last_r;
  logic [13:0] pix_cnt_r;
  logic [8:0]  ch_cnt_r;

  assign unused_s        = ^s_axis_tdata[63:48];
  assign stall_s         = m_axis_tvalid & ~m_axis_tready;
  assign accept_s        = s_axis_tvalid & ~stall_s;
  assign s_axis_tready   = ~stall_s;
  // Disabling the BRAM during a stall keeps doutb aligned with the held S1 beat.
  assign enb_noise_BRAM  = ~stall_s;
  assign noise_BRAM_addr = pix_cnt_r;

  assign size_sq_s    = 16'(Image_size) * 16'(Image_size);
  assign last_pix_s   = ({2'b00, pix_cnt_r} == (size_sq_s - 16'd1));
  assign last_ch_s    = (ch_cnt_r == (Channel_size - 9'd1));
  assign noise_prod_s = $signed(noise_BRAM_doutb) * $signed(noise_strength);
  assign noise_ext_s  = {{16{noise_prod_s[31]}}, noise_prod_s};

  // S3 combinational path: LeakyReLU on the S2 sum, then round-half-up requantise.
  always_comb begin
    sum_ext_s = {{16{s2_sum_r[47]}}, s2_sum_r};
    slope_s   = sum_ext_s * ALPHA_C;
    if (s2_sum_r[47]) begin
      act_s = slope_s >>> 16;
    end else begin
      act_s = sum_ext_s;
    end
    q_wide_s = (act_s + ROUND_C) >>> FRAC_SHIFT;
  end

  // S1 capture and S2 noise add.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid_r <= 1'b0;
      s1_acc_r   <= 48'd0;
      s1_last_r  <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_sum_r   <= 48'd0;
      s2_last_r  <= 1'b0;
    end else if (!stall_s) begin
      s1_valid_r <= accept_s;
      s1_acc_r   <= s_axis_tdata[47:0];
      s1_last_r  <= s_axis_tlast;
      s2_valid_r <= s1_valid_r;
      s2_sum_r   <= s1_acc_r + noise_ext_s;
      s2_last_r  <= s1_last_r;
    end
  end

  // S3 output registers drive the master stream directly.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 16'd0;
      m_axis_tlast  <= 1'b0;
    end else if (!stall_s) begin
      m_axis_tvalid <= s2_valid_r;
      m_axis_tdata  <= sat16(q_wide_s);
      m_axis_tlast  <= s2_last_r;
    end
  end

  // Frame position counters and sticky framing error.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pix_cnt_r <= 14'd0;
      ch_cnt_r  <= 9'd0;
      frame_err <= 1'b0;
    end else if (accept_s) begin
      if (s_axis_tlast) begin
        pix_cnt_r <= 14'd0;
        ch_cnt_r  <= 9'd0;
        if (!(last_pix_s && last_ch_s)) begin
          frame_err <= 1'b1;
        end
      end else if (last_pix_s) begin
        pix_cnt_r <= 14'd0;
        if (last_ch_s) begin
          ch_cnt_r  <= 9'd0;
          frame_err <= 1'b1;
        end else begin
          ch_cnt_r <= ch_cnt_r + 9'd1;
        end
      end else begin
        pix_cnt_r <= pix_cnt_r + 14'd1;
      end
    end
  end

endmodule

// File: doc/noise_lrelu_quant.md
NOISE_LRELU_QUANT -- requirements
Module: noise_lrelu_quant

Interface
REQ-001 Parameter: FRAC_SHIFT, default 8, right shift converting the Q16.16 accumulator to a Q8.8 output.
REQ-002 Parameter: LRELU_ALPHA, default 13107, LeakyReLU negative slope in unsigned Q0.16 (≈0.2).
REQ-003 The block SHALL have one clock, clk; reset is asynchronous and active-low, named aresetn.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock
- aresetn  in  1  async active-low reset
- Image_size  in  8  feature-map side (4..128)
- Channel_size  in  9  channels per frame (64/128/256)
- noise_strength  in  16  signed Q8.8 per-layer noise scale
- s_axis_tdata  in  64  sign-extended Q16.16 conv accumulator, bits [47:0] used
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last beat of frame
- noise_BRAM_addr  out  14  noise map read address
- enb_noise_BRAM  out  1  noise BRAM read enable
- noise_BRAM_doutb  in  16  signed Q8.8 noise, 1-cycle read latency
- m_axis_tdata  out  16  signed Q8.8 activation
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last beat, passed through
- frame_err  out  1  sticky tlast misalignment flag

Function
REQ-005 Three-stage pipeline (S1 capture, S2 noise add, S3 activation/requantise), one valid bit per stage.
REQ-006 stall = S3 valid AND NOT m_axis_tready; all stage registers and counters hold while stall.
REQ-007 s_axis_tready = NOT stall; beat accepted when s_axis_tvalid AND s_axis_tready.
REQ-008 Latency: m_axis_tvalid asserts 3 cycles after acceptance when not stalled; throughput 1 beat/cycle.
REQ-009 Pixel counter (14 b) counts accepted beats 0..Image_size²-1, then wraps to 0 and increments the channel counter (9 b, 0..Channel_size-1).
REQ-010 noise_BRAM_addr = pixel counter (combinational); enb_noise_BRAM = NOT stall, so doutb holds during a stall and is aligned with S1.
REQ-011 S2: sum = acc[47:0] + sign-extend48(noise_BRAM_doutb × noise_strength) (signed 32 b Q16.16 product, no shift).
REQ-012 S3 LeakyReLU: sum ≥ 0 → y = sum; sum < 0 → y = (sum × LRELU_ALPHA) >>> 16 (signed 64 b intermediate, arithmetic shift).
REQ-013 S3 requantise: q = (y + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, saturated to [-32768, 32767].
REQ-014 tlast travels with its beat through all stages to m_axis_tlast.
REQ-015 Accepted tlast resets both counters to 0 on that cycle. If tlast arrives when (pixel, channel) is not (Image_size²-1, Channel_size-1), or the last position passes without tlast, frame_err is set; it stays set until reset.
REQ-016 If no beat is accepted in a cycle, counters do not change.
REQ-017 m_axis_tdata, m_axis_tlast and m_axis_tvalid are driven directly from S3 registers; data and tlast are stable while m_axis_tvalid=1 and m_axis_tready=0.

Reset
REQ-018 aresetn low SHALL immediately clear all valid bits, counters and frame_err, and set m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
REQ-019 During reset, s_axis_tready=1 and enb_noise_BRAM=1.
REQ-020 Reset mid-frame SHALL discard in-flight beats. The first beat after release is pixel 0, channel 0.

Verification
REQ-021 Pass-through: noise_strength=0, acc=65536 (1.0), m_axis_tready=1 -> m_axis_tdata=0x0100, valid 3 cycles after acceptance.
REQ-022 Negative slope: acc=-65536, noise_strength=0 -> m_axis_tdata=0xFFCD (-51).
REQ-023 Noise add and saturation:
- noise=0x0100, noise_strength=0x0080, acc=65536 -> 0x0180 (384).
- acc=2^40 -> 0x7FFF.
- acc=-2^46 -> 0x8000 after slope.
REQ-024 Backpressure: stream 10 beats and hold m_axis_tready=0 for 5 cycles mid-stream -> no beat lost or duplicated, output order preserved, s_axis_tready low exactly during stall.
REQ-025 Framing: Image_size=4, Channel_size=64, noise_BRAM_addr cycles 0..15 per channel.
- tlast on beat 1024 -> frame_err=0, counters reset to 0.
- tlast on beat 1000 -> frame_err=1.
REQ-026 Reset mid-frame: assert aresetn=0 with 2 beats in flight -> m_axis_tvalid=0 at once; next frame starts at noise address 0.
